frame_capture_ctrl: RTL and testbench
=====================================

Name: frame_capture_ctrl

Overview:
Sequences capture of one rectangular camera window into the frame-buffer BRAM. Takes the pixel/coordinate stream from camera_coord, arms on request, and starts at the next frame boundary (vsync falling edge). It writes the window pixels row-major with a fixed stride. It also shares the single BRAM port between the capture writer and an external readback requester, such as manta or a display reader.

Parameters:
WIN_W, 100, window width in pixels (1..STRIDE)
WIN_H, 128, window height in rows
STRIDE, 120, BRAM words per row
ADDR_W, 14, BRAM address width; WIN_H*STRIDE must be <= 2**ADDR_W

Ports:
clk_in  input  1  camera pixel clock domain
rst_in  input  1  asynchronous reset, active-low
arm_in  input  1  one-cycle request to capture the next frame
abort_in  input  1  force return to IDLE
valid_in  input  1  pixel valid from camera_coord
data_in  input  16  pixel data
hcount_in  input  13  pixel column
vcount_in  input  12  pixel row
vsync_in  input  1  frame sync; falling edge = frame start
h_off_in  input  13  window origin column, sampled on arm
v_off_in  input  12  window origin row, sampled on arm
rd_req_in  input  1  readback requester wants the BRAM port
rd_addr_in  input  ADDR_W  readback address
rd_gnt_out  output  1  readback owns the port this cycle
fb_addr_out  output  ADDR_W  BRAM address
fb_din_out  output  16  BRAM write data
fb_we_out  output  1  BRAM write enable
busy_out  output  1  state is ARMED or CAPTURE
done_out  output  1  one-cycle pulse when a capture ends
short_out  output  1  last capture ended before the window was filled
frame_cnt_out  output  8  completed captures, wraps at 255

Behaviour:
- Reset (rst_in=0, async):
  - State is IDLE.
  - All outputs are 0; fb_addr_out=0.
  - Registered offsets, pixel counter and vsync_prev are 0.
- States:
  - IDLE:
    - arm_in=1 -> latch h_off_in/v_off_in -> ARMED.
  - ARMED:
    - vsync_prev=1 && vsync_in=0 -> CAPTURE; pixel counter=0.
  - CAPTURE: a pixel is in-window when valid_in=1, h_off<=hcount_in<h_off+WIN_W and v_off<=vcount_in<v_off+WIN_H.
    - Comparisons use 14-bit unsigned sums, so no wrap.
  - CAPTURE, in-window pixel, registered, 1-cycle latency:
    - fb_we_out=1.
    - fb_din_out=data_in.
    - fb_addr_out=(vcount_in-v_off)*STRIDE+(hcount_in-h_off), truncated to ADDR_W.
    - Pixel counter increments.
  - CAPTURE exit on the in-window pixel at (v_off+WIN_H-1, h_off+WIN_W-1):
    - That pixel is written.
    - Next cycle done_out=1 and short_out=0.
    - frame_cnt_out increments; state -> IDLE.
  - CAPTURE exit on a vsync falling edge before that pixel:
    - done_out=1 and short_out=1.
    - frame_cnt_out increments; state -> IDLE.
    - A pixel coincident with the edge is not written.
- abort_in:
  - In any state, abort_in=1 -> IDLE next cycle.
  - No done_out pulse; short_out and frame_cnt_out unchanged.
  - abort_in has priority over arm_in and over vsync edges.
- arm_in while ARMED or CAPTURE: ignored.
- arm_in in the same cycle as done_out's state transition: ignored; requesters re-arm after done_out.
- Arbitration:
  - rd_gnt_out=rd_req_in when state is IDLE or ARMED; 0 in CAPTURE.
  - When granted: fb_addr_out=rd_addr_in (registered, same 1-cycle latency) and fb_we_out=0.
  - On the ARMED->CAPTURE cycle, capture owns the port; rd_gnt_out drops that same cycle.
- short_out holds until the next done_out.
- fb_we_out is never asserted outside CAPTURE.
- Multiplication: use a constant-STRIDE multiply of a 12-bit row difference, with the product width sized to ADDR_W.

Optional Feature:
- CAPTURE_CONTINUOUS_EN defined:
  - After done_out the state goes to ARMED instead of IDLE, with the same offsets.
  - Captures repeat every frame until abort_in.
  - busy_out stays 1 between frames.
  - Readback is granted only in the ARMED gaps.
- Undefined: single-shot behaviour as above.

Test Plan:
- Reset mid-CAPTURE (rst_in low 1 cycle) -> fb_we_out=0, busy_out=0, frame_cnt_out=0 immediately, before the next clock edge.
- arm_in with offsets (0,0), WIN_W=4, WIN_H=2, STRIDE=8, full 6x3 frame -> 8 writes at addrs 0,1,2,3,8,9,10,11 with matching data; done_out one cycle after the last write; short_out=0; frame_cnt_out=1.
- Offsets (2,1), 6x4 frame -> only pixels col 2..5, row 1..2 written, at addrs 0..3 and 8..11.
- Vsync falling edge after 5 window pixels -> done_out=1, short_out=1, 5 writes total.
- rd_req_in held high across arm and the frame start -> rd_gnt_out=1 in IDLE/ARMED, 0 from the frame-start cycle, 1 again the cycle after done_out; no fb_we_out while granted.
- abort_in during CAPTURE -> IDLE next cycle, no done_out, frame_cnt_out unchanged.
- With CAPTURE_CONTINUOUS_EN: two frames -> two done_out pulses, frame_cnt_out=2, busy_out=1 throughout.

Source files
------------

// File: rtl/frame_capture_ctrl.sv
// -----------------------------------------------------------------------------
// frame_capture_ctrl
//
// Captures one rectangular window of the camera pixel stream into the frame
// buffer BRAM. A capture is armed by a one-cycle request, begins at the next
// vsync falling edge and writes the window row-major with a fixed row stride.
// The single BRAM port is shared with an external readback requester, which
// owns the port whenever no capture is in progress.
//
// Optional build macro:
//   CAPTURE_CONTINUOUS_EN - after each capture re-arm automatically with the
//                           same offsets, repeating every frame until abort.
//                           Undefined: single-shot capture.
// -----------------------------------------------------------------------------
module frame_capture_ctrl #(
   parameter int WIN_W  = 100,  // window width in pixels (1..STRIDE)
   parameter int WIN_H  = 128,  // window height in rows
   parameter int STRIDE = 120,  // BRAM words per row
   parameter int ADDR_W = 14    // BRAM address width
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              arm_in,
   input  logic              abort_in,
   input  logic              valid_in,
   input  logic [15:0]       data_in,
   input  logic [12:0]       hcount_in,
   input  logic [11:0]       vcount_in,
   input  logic              vsync_in,
   input  logic [12:0]       h_off_in,
   input  logic [11:0]       v_off_in,
   input  logic              rd_req_in,
   input  logic [ADDR_W-1:0] rd_addr_in,
   output logic              rd_gnt_out,
   output logic [ADDR_W-1:0] fb_addr_out,
   output logic [15:0]       fb_din_out,
   output logic              fb_we_out,
   output logic              busy_out,
   output logic              done_out,
   output logic              short_out,
   output logic [7:0]        frame_cnt_out
);

   // Pixel counter is wide enough to hold the full window size.
   localparam int              CNT_W     = $clog2(WIN_W * WIN_H + 1);
   localparam logic [CNT_W-1:0] PIX_TOTAL = CNT_W'(WIN_W * WIN_H);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   // State entered once a capture finishes (normally or short).
`ifdef CAPTURE_CONTINUOUS_EN
   localparam state_t DONE_STATE = ARMED;
`else
   localparam state_t DONE_STATE = IDLE;
`endif

   // ---------------------------------------------------------------------------
   // Registered state and its next-state values
   // ---------------------------------------------------------------------------
   state_t            state, state_n;
   logic [12:0]       h_off, h_off_n;
   logic [11:0]       v_off, v_off_n;
   logic [CNT_W-1:0]  pix_cnt, pix_cnt_n;
   logic              vsync_prev;
   logic              fin_pend, fin_pend_n;   // last window pixel written, done next
   logic [ADDR_W-1:0] fb_addr, fb_addr_n;
   logic [15:0]       fb_din, fb_din_n;
   logic              fb_we, fb_we_n;
   logic              done, done_n;
   logic              short_r, short_n;
   logic [7:0]        frame_cnt, frame_cnt_n;

   // ---------------------------------------------------------------------------
   // Window test and address generation
   // ---------------------------------------------------------------------------
   // Bounds are widened to 14 bits so origin + size never wraps.
   logic [13:0]       h_pos, h_lo, h_hi;
   logic [13:0]       v_pos, v_lo, v_hi;
   logic              in_win;
   logic              last_px;
   logic [11:0]       row_diff;
   logic [12:0]       col_diff;
   logic [ADDR_W-1:0] wr_addr;
   logic              frame_edge;
   logic              start_go;

   assign h_pos = {1'b0, hcount_in};
   assign h_lo  = {1'b0, h_off};
   assign h_hi  = h_lo + 14'(WIN_W);
   assign v_pos = {2'b00, vcount_in};
   assign v_lo  = {2'b00, v_off};
   assign v_hi  = v_lo + 14'(WIN_H);

   assign in_win = valid_in &&
                   (h_pos >= h_lo) && (h_pos < h_hi) &&
                   (v_pos >= v_lo) && (v_pos < v_hi);

   // Bottom-right corner of the window ends a complete capture.
   assign last_px = in_win &&
                    (h_pos == h_hi - 14'd1) &&
                    (v_pos == v_hi - 14'd1);

   // Only meaningful while in_win; the differences are then non-negative.
   assign row_diff = vcount_in - v_off;
   assign col_diff = hcount_in - h_off;
   assign wr_addr  = ADDR_W'(row_diff) * ADDR_W'(STRIDE) + ADDR_W'(col_diff);

   assign frame_edge = vsync_prev && !vsync_in;
   assign start_go   = (state == ARMED) && frame_edge && !abort_in;

   // Readback owns the port outside a capture, but capture claims it on the
   // very cycle the frame starts. Held off while reset is asserted.
   assign rd_gnt_out = rst_in && rd_req_in &&
                       ((state == IDLE) || ((state == ARMED) && !start_go));

   // ---------------------------------------------------------------------------
   // Next-state and next-output logic
   // ---------------------------------------------------------------------------
   // NOTE: every variable gets a default before the case so no path leaves one
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n     = state;
      h_off_n     = h_off;
      v_off_n     = v_off;
      pix_cnt_n   = pix_cnt;
      fin_pend_n  = 1'b0;
      fb_addr_n   = fb_addr;
      fb_din_n    = fb_din;
      fb_we_n     = 1'b0;
      done_n      = 1'b0;
      short_n     = short_r;
      frame_cnt_n = frame_cnt;

      if (rd_gnt_out) begin
         fb_addr_n = rd_addr_in;
      end

      if (abort_in) begin
         // Abort wins over arm, frame edges and pixels; no done pulse.
         state_n = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (arm_in) begin
                  h_off_n = h_off_in;
                  v_off_n = v_off_in;
                  state_n = ARMED;
               end
            end

            ARMED: begin
               if (frame_edge) begin
                  pix_cnt_n = '0;
                  state_n   = CAPTURE;
               end
            end

            CAPTURE: begin
               if (fin_pend) begin
                  // Window filled: report one cycle after the final write.
                  done_n      = 1'b1;
                  short_n     = 1'b0;
                  frame_cnt_n = frame_cnt + 8'd1;
                  state_n     = DONE_STATE;
               end else if (frame_edge) begin
                  // Frame ended early; a pixel on the edge cycle is dropped.
                  done_n      = 1'b1;
                  short_n     = 1'b1;
                  frame_cnt_n = frame_cnt + 8'd1;
                  state_n     = DONE_STATE;
               end else if (in_win && (pix_cnt < PIX_TOTAL)) begin
                  fb_we_n    = 1'b1;
                  fb_din_n   = data_in;
                  fb_addr_n  = wr_addr;
                  pix_cnt_n  = pix_cnt + CNT_W'(1);
                  fin_pend_n = last_px;
               end
            end

            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   // NOTE: non-blocking assignments here so every register samples the values
   // from before the edge, independent of statement order.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state      <= IDLE;
         h_off      <= '0;
         v_off      <= '0;
         pix_cnt    <= '0;
         vsync_prev <= 1'b0;
         fin_pend   <= 1'b0;
         fb_addr    <= '0;
         fb_din     <= '0;
         fb_we      <= 1'b0;
         done       <= 1'b0;
         short_r    <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         state      <= state_n;
         h_off      <= h_off_n;
         v_off      <= v_off_n;
         pix_cnt    <= pix_cnt_n;
         vsync_prev <= vsync_in;
         fin_pend   <= fin_pend_n;
         fb_addr    <= fb_addr_n;
         fb_din     <= fb_din_n;
         fb_we      <= fb_we_n;
         done       <= done_n;
         short_r    <= short_n;
         frame_cnt  <= frame_cnt_n;
      end
   end

   assign fb_addr_out   = fb_addr;
   assign fb_din_out    = fb_din;
   assign fb_we_out     = fb_we;
   assign busy_out      = (state != IDLE);
   assign done_out      = done;
   assign short_out     = short_r;
   assign frame_cnt_out = frame_cnt;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frame_capture_ctrl
//
// Directed bench for frame_capture_ctrl with a small window (4x2, stride 8).
// A behavioural model predicts every output each cycle from the capture
// rules; directed scenarios additionally pin write lists, timing and counters
// to hand-computed constants. Build with CAPTURE_CONTINUOUS_EN to exercise
// repeated captures.
// -----------------------------------------------------------------------------
module tb_frame_capture_ctrl;

   localparam int WIN_W  = 4;
   localparam int WIN_H  = 2;
   localparam int STRIDE = 8;
   localparam int ADDR_W = 14;

   localparam int M_IDLE  = 0;
   localparam int M_ARMED = 1;
   localparam int M_CAPT  = 2;
   localparam int M_TAIL  = 3;   // final window pixel written, done pending

`ifdef CAPTURE_CONTINUOUS_EN
   localparam int M_AFTER = M_ARMED;
`else
   localparam int M_AFTER = M_IDLE;
`endif

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              arm = 1'b0, abort = 1'b0, valid = 1'b0, vsync = 1'b0;
   logic [15:0]       data = '0;
   logic [12:0]       hcount = '0, h_off = '0;
   logic [11:0]       vcount = '0, v_off = '0;
   logic              rd_req = 1'b0;
   logic [ADDR_W-1:0] rd_addr = '0;
   logic              rd_gnt, fb_we, busy, done, short_o;
   logic [ADDR_W-1:0] fb_addr;
   logic [15:0]       fb_din;
   logic [7:0]        frame_cnt;

   frame_capture_ctrl #(
      .WIN_W(WIN_W), .WIN_H(WIN_H), .STRIDE(STRIDE), .ADDR_W(ADDR_W)
   ) dut (
      .clk_in(clk), .rst_in(rst_n), .arm_in(arm), .abort_in(abort),
      .valid_in(valid), .data_in(data), .hcount_in(hcount), .vcount_in(vcount),
      .vsync_in(vsync), .h_off_in(h_off), .v_off_in(v_off),
      .rd_req_in(rd_req), .rd_addr_in(rd_addr), .rd_gnt_out(rd_gnt),
      .fb_addr_out(fb_addr), .fb_din_out(fb_din), .fb_we_out(fb_we),
      .busy_out(busy), .done_out(done), .short_out(short_o),
      .frame_cnt_out(frame_cnt)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: outputs derived from the capture rules each clock
   // ---------------------------------------------------------------------------
   int m_mode = M_IDLE;
   int m_hoff = 0, m_voff = 0;
   bit m_vsp = 0;
   bit e_we = 0, e_done = 0, e_short = 0;
   int e_addr = 0, e_din = 0, e_cnt = 0;

   task automatic model_step();
      bit fs, go, g;
      int h, v;
      if (!rst_n) begin
         m_mode = M_IDLE; m_hoff = 0; m_voff = 0; m_vsp = 0;
         e_we = 0; e_done = 0; e_short = 0; e_addr = 0; e_din = 0; e_cnt = 0;
         return;
      end
      h  = int'(hcount);
      v  = int'(vcount);
      fs = m_vsp && !vsync;
      go = (m_mode == M_ARMED) && fs && !abort;
      g  = rd_req && (m_mode == M_IDLE || (m_mode == M_ARMED && !go));
      e_we   = 0;
      e_done = 0;
      if (g) e_addr = int'(rd_addr);
      if (abort) begin
         m_mode = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE:  if (arm) begin m_hoff = int'(h_off); m_voff = int'(v_off); m_mode = M_ARMED; end
            M_ARMED: if (fs) m_mode = M_CAPT;
            M_CAPT: begin
               if (fs) begin
                  e_done = 1; e_short = 1; e_cnt = (e_cnt + 1) % 256; m_mode = M_AFTER;
               end else if (valid && h >= m_hoff && h < m_hoff + WIN_W &&
                            v >= m_voff && v < m_voff + WIN_H) begin
                  e_we   = 1;
                  e_din  = int'(data);
                  e_addr = ((v - m_voff) * STRIDE + (h - m_hoff)) % (1 << ADDR_W);
                  if (v == m_voff + WIN_H - 1 && h == m_hoff + WIN_W - 1) m_mode = M_TAIL;
               end
            end
            M_TAIL: begin
               e_done = 1; e_short = 0; e_cnt = (e_cnt + 1) % 256; m_mode = M_AFTER;
            end
            default: m_mode = M_IDLE;
         endcase
      end
      m_vsp = vsync;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      model_step();
   end

   // ---------------------------------------------------------------------------
   // Per-cycle compare against the model, plus observation records
   // ---------------------------------------------------------------------------
   int          cyc = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          last_we_cyc = -1, done_cyc = -1, done_cnt = 0;
   int          clash = 0, busy_low = 0;
   bit          prev_done = 0;
   bit          gnt_after_done = 0;

   initial forever begin
      bit exp_gnt;
      @(negedge clk);
      cyc++;
      exp_gnt = rst_n && rd_req &&
                (m_mode == M_IDLE || (m_mode == M_ARMED && !(m_vsp && !vsync && !abort)));
      check("we",    32'(fb_we),     32'(e_we));
      check("addr",  32'(fb_addr),   32'(e_addr));
      check("din",   32'(fb_din),    32'(e_din));
      check("done",  32'(done),      32'(e_done));
      check("short", 32'(short_o),   32'(e_short));
      check("cnt",   32'(frame_cnt), 32'(e_cnt));
      check("busy",  32'(busy),      32'(m_mode != M_IDLE));
      check("gnt",   32'(rd_gnt),    32'(exp_gnt));
      if (rd_gnt && fb_we) clash++;
      if (!busy) busy_low++;
      if (fb_we) begin
         wr_addr_q.push_back(32'(fb_addr));
         wr_data_q.push_back(32'(fb_din));
         last_we_cyc = cyc;
      end
      if (prev_done) gnt_after_done = rd_gnt;
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      prev_done = done;
   end

   // Readback address keeps moving so registered address capture is visible.
   initial forever begin
      @(posedge clk);
      #2;
      rd_addr = ADDR_W'(cyc * 37 + 5);
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers (inputs change 2 time units after the rising edge)
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [15:0] pix(input int h, input int v);
      return 16'(32'hA000 + v * 256 + h);
   endfunction

   task automatic clear_obs();
      wr_addr_q.delete();
      wr_data_q.delete();
   endtask

   task automatic arm_at(input int h, input int v);
      arm = 1; h_off = 13'(h); v_off = 12'(v);
      tick();
      arm = 0; h_off = 13'd7; v_off = 12'd3;   // junk: offsets must be latched
      tick();
   endtask

   // vsync high for two cycles, then a falling edge with an optional pixel.
   task automatic frame_edge(input bit px, input int h, input int v, output bit g_edge);
      valid = 0; vsync = 1;
      tick();
      tick();
      vsync = 0; valid = px; hcount = 13'(h); vcount = 12'(v); data = pix(h, v);
      #1 g_edge = rd_gnt;
      tick();
      valid = 0;
   endtask

   // Raster of cols x rows pixels, stopping after max_px valid pixels.
   task automatic pixels(input int cols, input int rows, input int max_px);
      int n = 0;
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < cols; c++) begin
            if (n < max_px) begin
               valid = 1; hcount = 13'(c); vcount = 12'(r); data = pix(c, r);
               tick();
               n++;
            end
         end
         valid = 0;
         tick();
      end
   endtask

   task automatic check_writes(input string tag, input int n,
                               input int exp_a[8], input int exp_d[8]);
      check({tag, "_nwr"}, 32'(wr_addr_q.size()), 32'(n));
      for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
         check($sformatf("%s_a%0d", tag, i), wr_addr_q[i], 32'(exp_a[i]));
         check($sformatf("%s_d%0d", tag, i), wr_data_q[i], 32'(exp_d[i]));
      end
   endtask

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      bit g;
      int base_done;
      int a_full[8] = '{0, 1, 2, 3, 8, 9, 10, 11};

      // Reset state, with a readback request that must stay ungranted.
      tick();
      rd_req = 1;
      #1;
      check("rst_gnt",  32'(rd_gnt),    0);
      check("rst_we",   32'(fb_we),     0);
      check("rst_addr", 32'(fb_addr),   0);
      check("rst_busy", 32'(busy),      0);
      check("rst_done", 32'(done),      0);
      check("rst_cnt",  32'(frame_cnt), 0);
      rd_req = 0;
      tick();
      rst_n = 1;
      tick();

`ifdef CAPTURE_CONTINUOUS_EN
      // Two consecutive frames captured from one arm.
      clear_obs();
      base_done = done_cnt;
      arm_at(0, 0);
      busy_low = 0;
      frame_edge(0, 0, 0, g);
      pixels(6, 3, 99);
      frame_edge(0, 0, 0, g);
      pixels(6, 3, 99);
      tick(); tick(); tick();
      check("cont_done",   32'(done_cnt - base_done), 2);
      check("cont_cnt",    32'(frame_cnt), 2);
      check("cont_busy",   32'(busy_low), 0);
      check("cont_nwr",    32'(wr_addr_q.size()), 16);
      abort = 1;
      tick();
      abort = 0;
      #1 check("cont_abort_busy", 32'(busy), 0);
      tick();
`else
      // Full window at origin (0,0) from a 6x3 frame.
      begin
         int d1[8] = '{'hA000, 'hA001, 'hA002, 'hA003, 'hA100, 'hA101, 'hA102, 'hA103};
         clear_obs();
         arm_at(0, 0);
         frame_edge(0, 0, 0, g);
         pixels(6, 3, 99);
         tick(); tick();
         check_writes("t1", 8, a_full, d1);
         check("t1_done_lat", 32'(done_cyc - last_we_cyc), 1);
         check("t1_short",    32'(short_o), 0);
         check("t1_cnt",      32'(frame_cnt), 1);
      end

      // Window at (2,1) from a 6x4 frame.
      begin
         int d2[8] = '{'hA102, 'hA103, 'hA104, 'hA105, 'hA202, 'hA203, 'hA204, 'hA205};
         clear_obs();
         arm_at(2, 1);
         frame_edge(0, 0, 0, g);
         pixels(6, 4, 99);
         tick(); tick();
         check_writes("t2", 8, a_full, d2);
         check("t2_cnt", 32'(frame_cnt), 2);
      end

      // Short capture: 5 window pixels, then a frame edge carrying a window pixel.
      begin
         int d3[8] = '{'hA000, 'hA001, 'hA002, 'hA003, 'hA100, 0, 0, 0};
         clear_obs();
         base_done = done_cnt;
         arm_at(0, 0);
         frame_edge(0, 0, 0, g);
         pixels(6, 3, 7);
         frame_edge(1, 1, 1, g);
         tick();
         check_writes("t3", 5, a_full, d3);
         check("t3_done",  32'(done_cnt - base_done), 1);
         check("t3_short", 32'(short_o), 1);
         check("t3_cnt",   32'(frame_cnt), 3);
         tick(); tick(); tick();
         #1 check("t3_short_hold", 32'(short_o), 1);
      end

      // Readback held across arm and the whole capture.
      begin
         clear_obs();
         gnt_after_done = 0;
         clash = 0;
         rd_req = 1;
         tick();
         #1 check("t4_gnt_idle", 32'(rd_gnt), 1);
         arm_at(0, 0);
         #1 check("t4_gnt_armed", 32'(rd_gnt), 1);
         frame_edge(0, 0, 0, g);
         check("t4_gnt_edge", 32'(g), 0);
         #1 check("t4_gnt_capt", 32'(rd_gnt), 0);
         pixels(6, 3, 99);
         tick(); tick();
         check("t4_gnt_after", 32'(gnt_after_done), 1);
         check("t4_clash",     32'(clash), 0);
         check("t4_nwr",       32'(wr_addr_q.size()), 8);
         check("t4_short",     32'(short_o), 0);
         check("t4_cnt",       32'(frame_cnt), 4);
         rd_req = 0;
         tick();
      end

      // Abort mid-capture, with an in-window pixel on the abort cycle.
      begin
         clear_obs();
         base_done = done_cnt;
         arm_at(0, 0);
         frame_edge(0, 0, 0, g);
         pixels(6, 3, 3);
         abort = 1; valid = 1; hcount = 13'd3; vcount = 12'd0; data = pix(3, 0);
         tick();
         abort = 0; valid = 0;
         #1;
         check("t5_busy", 32'(busy), 0);
         check("t5_we",   32'(fb_we), 0);
         frame_edge(0, 0, 0, g);
         pixels(6, 3, 99);
         tick(); tick();
         check("t5_nwr",  32'(wr_addr_q.size()), 3);
         check("t5_done", 32'(done_cnt - base_done), 0);
         check("t5_cnt",  32'(frame_cnt), 4);
      end
`endif

      // Asynchronous reset in the middle of a capture.
      arm_at(0, 0);
      frame_edge(0, 0, 0, g);
      valid = 1; hcount = 13'd0; vcount = 12'd0; data = pix(0, 0);
      tick();
      hcount = 13'd1; data = pix(1, 0);
      tick();
      #1 check("t6_we_pre", 32'(fb_we), 1);
      rst_n = 0;
      #1;
      check("t6_we",   32'(fb_we),     0);
      check("t6_busy", 32'(busy),      0);
      check("t6_cnt",  32'(frame_cnt), 0);
      tick();
      rst_n = 1; valid = 0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Safety net: the directed sequence is far shorter than this.
   initial begin
      #500000;
      $display("FAIL timeout: sequence did not finish, got no end, expected end");
      fails++;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "timeout");
   end

endmodule
